operand_stage: RTL and testbench
================================

// Module: operand_stage
// PURPOSE
//   Decode-to-execute operand stage, directly upstream of the 16-bit ALU.
//   - Holds the 4 x 16-bit architectural register file.
//   - Reads the rs/rt operands and selects register or immediate for ALU input B.
//   - Bypasses the same-cycle write-back value.
//   - Latches everything into a registered valid/ready output slot that drives the ALU A, B, Cin and OP inputs.
// PARAMETERS
//   WIDTH  16  datapath width; must match ALU operand width
//   NREG   4   number of architectural registers
//   AW     2   register index width, AW = log2(NREG)
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   reset        in   1      synchronous, active-high
//   in_valid     in   1      decode presents an instruction
//   in_ready     out  1      stage accepts it this cycle
//   in_rs        in   AW     source for ALU A
//   in_rt        in   AW     source for ALU B when in_use_imm=0
//   in_dst       in   AW     destination register, forwarded downstream
//   in_wb_en     in   1      instruction writes in_dst, forwarded downstream
//   in_use_imm   in   1      B comes from immediate
//   in_imm_zext  in   1      1: zero-extend imm8; 0: sign-extend imm8
//   in_imm       in   8      immediate field
//   in_op        in   4      ALU opcode, passed through unchanged
//   in_cin       in   1      ALU carry-in, passed through unchanged
//   flush        in   1      kill the slot contents (branch redirect)
//   wb_en        in   1      write-back strobe
//   wb_addr      in   AW     write-back register
//   wb_data      in   WIDTH  write-back value
//   out_valid    out  1      slot holds a valid instruction
//   out_ready    in   1      ALU/execute consumes the slot
//   out_a        out  WIDTH  ALU A
//   out_b        out  WIDTH  ALU B
//   out_op       out  4      ALU OP
//   out_cin      out  1      ALU Cin
//   out_dst      out  AW     destination register for write-back
//   out_wb_en    out  1      write-back enable for write-back
// BEHAVIOUR
//   Reset
//   - All NREG registers = 0.
//   - out_valid = 0; out_a, out_b, out_dst = 0; out_op = 4'h0; out_cin = 0; out_wb_en = 0.
//   - Reset overrides flush, load and write-back in the same cycle.
//   Register file
//   - wb_en=1 writes wb_data to reg[wb_addr] at the clock edge.
//   - Reads are combinational.
//   Bypass
//   - If wb_en && wb_addr == in_rs, operand A = wb_data instead of reg[in_rs]; same rule for in_rt.
//   - So an instruction loaded in the write cycle sees the new value.
//   Operand B
//   - in_use_imm=0: reg[in_rt], bypassed as above.
//   - in_use_imm=1 and in_imm_zext=1: {8'h00, in_imm}. LHI uses this; the ALU takes B[7:0].
//   - in_use_imm=1 and in_imm_zext=0: {{8{in_imm[7]}}, in_imm}.
//   Handshake
//   - in_ready = !out_valid || out_ready. It is combinational and ignores flush.
//   - Load condition: in_valid && in_ready && !flush. On load, all out_* capture next-cycle values and out_valid = 1.
//   - If the slot is not loaded and out_ready=1, out_valid -> 0 next cycle.
//   - Otherwise the slot holds; out_* stay stable while out_valid && !out_ready.
//   Latency
//   - One cycle from accepted input to out_valid.
//   - Throughput is 1 instruction/cycle when out_ready stays high.
//   Flush
//   - flush=1: out_valid -> 0 next cycle, and the incoming instruction is dropped even if in_ready=1.
//   - Data fields may keep stale values; the register file is unaffected.
//   Simultaneous events
//   - Write-back still occurs during a stall or flush.
//   - A slot already loaded does NOT see later writes. Stale-operand hazards are handled by the decode interlock, not here.
//   - Reset mid-stall discards the held slot.
//   Width and pass-through
//   - No arithmetic is done here.
//   - out_op and out_cin are pure registered copies of in_op and in_cin.
// TESTING
//   1. Reset, then check all registers by issuing rs=0..3 with use_imm=0 -> out_a = out_b = 16'h0000 and out_valid=0 until the first load.
//   2. wb_en=1, wb_addr=2, wb_data=16'hBEEF in the same cycle as load rs=2, rt=2 -> next cycle out_a = out_b = 16'hBEEF (bypass).
//   3. use_imm=1, imm=8'hF0: zext=0 -> out_b = 16'hFFF0; zext=1 -> out_b = 16'h00F0.
//   4. out_valid=1 and out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and out_* frozen; out_ready=1 -> the next instruction loads on that edge.
//   5. flush=1 together with in_valid=1 and in_ready=1 -> out_valid=0 next cycle; a write-back with wb_en=1 in the same cycle still updates the register.
//   6. Back-to-back stream of 8 instructions with out_ready=1 -> 8 consecutive out_valid cycles with op/cin/dst/wb_en matching the inputs in order.

Source files
------------

// File: rtl/operand_stage_if.sv
// ---------------------------------------------------------------------------
// operand_stage_if
//   Bundles the decode-side input handshake, the write-back port and the
//   registered output slot that feeds the 16-bit ALU.
//   master : the surrounding pipeline (decode, write-back, execute)
//   slave  : operand_stage
//   Signals
//     in_valid/in_ready   decode handshake
//     in_rs/in_rt/in_dst  register indices
//     in_wb_en            instruction writes in_dst
//     in_use_imm          B from immediate
//     in_imm_zext         1 zero-extend, 0 sign-extend imm8
//     in_imm/in_op/in_cin immediate, ALU opcode, carry-in
//     flush               kill slot contents
//     wb_en/wb_addr/wb_data  register write-back
//     out_valid/out_ready output slot handshake
//     out_a/out_b/out_op/out_cin/out_dst/out_wb_en  slot contents
// ---------------------------------------------------------------------------
interface operand_stage_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [AW-1:0]    in_rs;
   logic [AW-1:0]    in_rt;
   logic [AW-1:0]    in_dst;
   logic             in_wb_en;
   logic             in_use_imm;
   logic             in_imm_zext;
   logic [7:0]       in_imm;
   logic [3:0]       in_op;
   logic             in_cin;
   logic             flush;
   logic             wb_en;
   logic [AW-1:0]    wb_addr;
   logic [WIDTH-1:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [3:0]       out_op;
   logic             out_cin;
   logic [AW-1:0]    out_dst;
   logic             out_wb_en;

   modport master (
      output in_valid, in_rs, in_rt, in_dst, in_wb_en, in_use_imm,
             in_imm_zext, in_imm, in_op, in_cin, flush,
             wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_op, out_cin,
             out_dst, out_wb_en
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_dst, in_wb_en, in_use_imm,
             in_imm_zext, in_imm, in_op, in_cin, flush,
             wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, out_a, out_b, out_op, out_cin,
             out_dst, out_wb_en
   );
endinterface

// File: rtl/operand_stage.sv
// ---------------------------------------------------------------------------
// operand_stage
//   Decode-to-execute operand stage in front of the 16-bit ALU. Holds the
//   architectural register file, reads rs/rt with same-cycle write-back
//   bypass, selects register or extended immediate for operand B, and
//   captures everything into a single valid/ready output slot.
//   Ports
//     clk    in  single clock, rising edge
//     reset  in  synchronous, active-high
//     bus    slave modport of operand_stage_if (handshake, write-back, slot)
// ---------------------------------------------------------------------------
module operand_stage #(
   parameter int WIDTH = 16,
   parameter int NREG  = 4,
   parameter int AW    = 2
) (
   input  logic            clk,
   input  logic            reset,
   operand_stage_if.slave  bus
);

   logic [WIDTH-1:0] r_regs [NREG];

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_a;
   logic [WIDTH-1:0] r_out_b;
   logic [3:0]       r_out_op;
   logic             r_out_cin;
   logic [AW-1:0]    r_out_dst;
   logic             r_out_wb_en;

   logic             w_in_ready;
   logic             w_load;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_reg_b;
   logic [WIDTH-1:0] w_imm_ext;
   logic [WIDTH-1:0] w_op_b;

   // Register file: one write port; write-back is independent of the slot
   // handshake, so it proceeds through stalls and flushes.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
         always_ff @(posedge clk) begin
            if (reset) begin
               r_regs[gi] <= '0;
            end else if (bus.wb_en && (bus.wb_addr == AW'(gi))) begin
               r_regs[gi] <= bus.wb_data;
            end
         end
      end
   endgenerate

   // Bypass: an instruction accepted in the write-back cycle must see the
   // value being written, since the array only updates at the edge.
   assign w_op_a  = (bus.wb_en && (bus.wb_addr == bus.in_rs)) ? bus.wb_data
                                                              : r_regs[bus.in_rs];
   assign w_reg_b = (bus.wb_en && (bus.wb_addr == bus.in_rt)) ? bus.wb_data
                                                              : r_regs[bus.in_rt];

   assign w_imm_ext = bus.in_imm_zext ? {{(WIDTH-8){1'b0}}, bus.in_imm}
                                      : {{(WIDTH-8){bus.in_imm[7]}}, bus.in_imm};
   assign w_op_b    = bus.in_use_imm ? w_imm_ext : w_reg_b;

   // in_ready deliberately ignores flush so it stays a simple function of
   // slot occupancy; flush only suppresses the load itself.
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_load     = bus.in_valid && w_in_ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_a     <= '0;
         r_out_b     <= '0;
         r_out_op    <= 4'h0;
         r_out_cin   <= 1'b0;
         r_out_dst   <= '0;
         r_out_wb_en <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_a     <= w_op_a;
         r_out_b     <= w_op_b;
         r_out_op    <= bus.in_op;
         r_out_cin   <= bus.in_cin;
         r_out_dst   <= bus.in_dst;
         r_out_wb_en <= bus.in_wb_en;
      end else if (bus.flush || bus.out_ready) begin
         // Data fields are left stale; only the valid bit is cleared.
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_a     = r_out_a;
   assign bus.out_b     = r_out_b;
   assign bus.out_op    = r_out_op;
   assign bus.out_cin   = r_out_cin;
   assign bus.out_dst   = r_out_dst;
   assign bus.out_wb_en = r_out_wb_en;

endmodule

// File: tb/tb_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_operand_stage
//   Scoreboard bench: a register-file model computes each accepted
//   instruction's slot contents when it is driven; the entry is compared
//   while it sits in the output slot and popped when consumed or flushed.
// ---------------------------------------------------------------------------
module tb_operand_stage;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic        cin;
      logic [1:0]  dst;
      logic        wb_en;
   } slot_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] m_regs [4];
   logic        m_valid;
   slot_t       sbq [$];

   operand_stage_if #(.WIDTH(16), .AW(2)) bus ();

   operand_stage #(.WIDTH(16), .NREG(4), .AW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic slot_t act_slot();
      slot_t s;
      s.a     = bus.out_a;
      s.b     = bus.out_b;
      s.op    = bus.out_op;
      s.cin   = bus.out_cin;
      s.dst   = bus.out_dst;
      s.wb_en = bus.out_wb_en;
      return s;
   endfunction

   task automatic set_instr(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                            input logic [1:0] dst, input logic wbe, input logic use_imm,
                            input logic zext, input logic [7:0] imm,
                            input logic [3:0] op, input logic cin);
      bus.in_valid    = v;
      bus.in_rs       = rs;
      bus.in_rt       = rt;
      bus.in_dst      = dst;
      bus.in_wb_en    = wbe;
      bus.in_use_imm  = use_imm;
      bus.in_imm_zext = zext;
      bus.in_imm      = imm;
      bus.in_op       = op;
      bus.in_cin      = cin;
   endtask

   task automatic set_wb(input logic en, input logic [1:0] addr, input logic [15:0] data);
      bus.wb_en   = en;
      bus.wb_addr = addr;
      bus.wb_data = data;
   endtask

   // Advance one clock while updating the model with the inputs now driven.
   task automatic step();
      logic  rdy, ld;
      slot_t e;
      #1;
      rdy = !m_valid || bus.out_ready;
      ld  = bus.in_valid && rdy && !bus.flush;
      e.a = (bus.wb_en && bus.wb_addr == bus.in_rs) ? bus.wb_data : m_regs[bus.in_rs];
      if (bus.in_use_imm)
         e.b = bus.in_imm_zext ? {8'h00, bus.in_imm} : {{8{bus.in_imm[7]}}, bus.in_imm};
      else
         e.b = (bus.wb_en && bus.wb_addr == bus.in_rt) ? bus.wb_data : m_regs[bus.in_rt];
      e.op = bus.in_op; e.cin = bus.in_cin; e.dst = bus.in_dst; e.wb_en = bus.in_wb_en;
      if (reset) begin
         sbq.delete();
         m_valid = 1'b0;
         for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
      end else begin
         if (m_valid && (bus.out_ready || bus.flush)) begin
            if (sbq.size() > 0) begin
               if (!bus.flush)
                  $display("txn: a=%h b=%h op=%h cin=%b dst=%0d wb_en=%b",
                           sbq[0].a, sbq[0].b, sbq[0].op, sbq[0].cin, sbq[0].dst, sbq[0].wb_en);
               void'(sbq.pop_front());
            end
         end
         if (ld) sbq.push_back(e);
         m_valid = ld ? 1'b1 : ((bus.flush || bus.out_ready) ? 1'b0 : m_valid);
         if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Drive a load and a write during reset: reset must win.
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      set_instr(1'b1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 8'h55, 4'hA, 1'b1);
      set_wb(1'b1, 2'd0, 16'h1234);
      step();
      step();
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      total++;
      if (act_slot() !== '0) begin bad++; $display("FAIL reset_fields got=%h exp=0", act_slot()); end
      reset = 1'b0;
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      set_wb(1'b0, 2'd0, 16'h0000);
      step();
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", bus.out_valid); end
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_regs_zero();
      for (int r = 0; r < 4; r++) begin
         set_instr(1'b1, 2'(r), 2'(r), 2'(r), 1'b1, 1'b0, 1'b0, 8'h00, 4'(r + 1), 1'b0);
         step();
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
            bad++;
            $display("FAIL regs_zero r=%0d got v=%b a=%h b=%h exp v=1 a=0000 b=0000",
                     r, bus.out_valid, bus.out_a, bus.out_b);
         end
         total++;
         if (sbq.size() == 0 || act_slot() !== sbq[0]) begin
            bad++; $display("FAIL regs_zero_slot r=%0d got=%h", r, act_slot());
         end
      end
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
   endtask

   task automatic test_bypass();
      set_wb(1'b1, 2'd2, 16'hBEEF);
      set_instr(1'b1, 2'd2, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 4'h3, 1'b1);
      step();
      set_wb(1'b0, 2'd0, 16'h0000);
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      total++;
      if (bus.out_a !== 16'hBEEF || bus.out_b !== 16'hBEEF) begin
         bad++; $display("FAIL bypass got a=%h b=%h exp a=BEEF b=BEEF", bus.out_a, bus.out_b);
      end
      total++;
      if (sbq.size() == 0 || act_slot() !== sbq[0]) begin
         bad++; $display("FAIL bypass_slot got=%h", act_slot());
      end
      step();
   endtask

   task automatic test_imm();
      set_instr(1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 8'hF0, 4'h7, 1'b0);
      step();
      total++;
      if (bus.out_b !== 16'hFFF0 || bus.out_a !== 16'hBEEF) begin
         bad++; $display("FAIL imm_sext got a=%h b=%h exp a=BEEF b=FFF0", bus.out_a, bus.out_b);
      end
      set_instr(1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 8'hF0, 4'h8, 1'b0);
      step();
      total++;
      if (bus.out_b !== 16'h00F0) begin
         bad++; $display("FAIL imm_zext got b=%h exp b=00F0", bus.out_b);
      end
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
   endtask

   task automatic test_stall();
      slot_t snap;
      bus.out_ready = 1'b0;
      set_instr(1'b1, 2'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 4'h5, 1'b1);
      step();
      snap = act_slot();
      total++;
      if (bus.out_valid !== 1'b1 || sbq.size() == 0 || snap !== sbq[0]) begin
         bad++; $display("FAIL stall_load got v=%b slot=%h", bus.out_valid, snap);
      end
      set_instr(1'b1, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'h9, 1'b0);
      for (int c = 0; c < 3; c++) begin
         // A write to reg0 during the stall must not reach the held slot.
         set_wb(c == 0, 2'd0, 16'h1111);
         #1;
         total++;
         if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, bus.in_ready);
         end
         step();
         total++;
         if (bus.out_valid !== 1'b1 || act_slot() !== snap) begin
            bad++; $display("FAIL stall_frozen c=%0d got v=%b slot=%h exp slot=%h",
                            c, bus.out_valid, act_slot(), snap);
         end
      end
      set_wb(1'b0, 2'd0, 16'h0000);
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_op !== 4'h9 || bus.out_a !== 16'h1111
          || sbq.size() == 0 || act_slot() !== sbq[0]) begin
         bad++; $display("FAIL release_load got v=%b op=%h a=%h exp v=1 op=9 a=1111",
                         bus.out_valid, bus.out_op, bus.out_a);
      end
   endtask

   task automatic test_flush();
      // Slot is currently valid; flush kills it and drops the incoming instruction.
      bus.flush = 1'b1;
      set_instr(1'b1, 2'd3, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 4'hC, 1'b0);
      set_wb(1'b1, 2'd1, 16'h1234);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
      step();
      bus.flush = 1'b0;
      set_wb(1'b0, 2'd0, 16'h0000);
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
      set_instr(1'b1, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'hD, 1'b0);
      step();
      total++;
      if (bus.out_a !== 16'h1234 || bus.out_b !== 16'h1234) begin
         bad++; $display("FAIL flush_wb got a=%h b=%h exp a=1234 b=1234", bus.out_a, bus.out_b);
      end
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
   endtask

   task automatic test_reset_mid_stall();
      bus.out_ready = 1'b0;
      set_instr(1'b1, 2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 4'hE, 1'b1);
      step();
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || act_slot() !== '0) begin
         bad++; $display("FAIL reset_stall got v=%b slot=%h exp v=0 slot=0", bus.out_valid, act_slot());
      end
      bus.out_ready = 1'b1;
      set_instr(1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h1, 1'b0);
      step();
      total++;
      if (bus.out_a !== 16'h0000 || bus.out_b !== 16'h0000) begin
         bad++; $display("FAIL reset_clears_rf got a=%h b=%h exp 0", bus.out_a, bus.out_b);
      end
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
   endtask

   task automatic test_back_to_back();
      int run = 0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         set_wb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
         set_instr(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
         step();
         if (bus.out_valid === 1'b1) run++;
         total++;
         if (bus.out_valid !== 1'b1 || sbq.size() == 0 || act_slot() !== sbq[0]) begin
            bad++; $display("FAIL b2b n=%0d got v=%b slot=%h exp=%h", n, bus.out_valid, act_slot(),
                            (sbq.size() > 0) ? sbq[0] : slot_t'('0));
         end
      end
      set_wb(1'b0, 2'd0, 16'h0000);
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      step();
      total++;
      if (run != 8 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_run got=%0d final_v=%b exp 8 and 0", run, bus.out_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
      m_valid = 1'b0;
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      set_instr(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
      set_wb(1'b0, 2'd0, 16'h0000);
      @(posedge clk);
      #1;
      test_reset();
      test_regs_zero();
      test_bypass();
      test_imm();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
